adc_capture_multi: RTL and testbench

ADC_CAPTURE_MULTI -- requirements
Module: adc_capture_multi

---
 rtl/adc_capture_multi.sv | 172 +++++++++++++++++
 tb/tb_adc_capture_multi.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_multi.sv
// Multi-channel serial ADC capture: generates sclk/cs1 frames, deserializes NUM_CH
// data lines in parallel and presents each sample set on an AXI-stream port.

module adc_capture_lane #(
   parameter int DATA_BITS  = 10,
   parameter bit SIGNED_OUT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        shift_en,
   input  logic        din,
   output logic [15:0] word
);
   logic [DATA_BITS-2:0] shreg;
   logic [DATA_BITS-1:0] full;

   // full includes the bit sampled this cycle, so on the last bit it is the finished sample
   assign full = {shreg, din};

   always_ff @(posedge clk) begin
      if (reset)         shreg <= '0;
      else if (shift_en) shreg <= full[DATA_BITS-2:0];
   end

   always_comb begin
      word = 16'(full);
      if (SIGNED_OUT) word = 16'($signed({~full[DATA_BITS-1], full[DATA_BITS-2:0]}));
   end
endmodule

module adc_capture_multi #(
   parameter int NUM_CH     = 2,
   parameter int DATA_BITS  = 10,
   parameter int LEAD_BITS  = 5,
   parameter int SCLK_DIV   = 7,
   parameter int GAP_BITS   = 2,
   parameter int BLOCK_LEN  = 256,
   parameter bit SIGNED_OUT = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 single,
   input  logic [NUM_CH-1:0]    adc_din,
   output logic                 sclk,
   output logic                 cs1,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic [16*NUM_CH-1:0] m_tdata,
   output logic                 busy,
   output logic                 block_done,
   output logic [15:0]          overrun_cnt
);
   localparam int FRAME_BITS = LEAD_BITS + DATA_BITS;
   localparam int CNT_MAX    = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
   localparam int DIV_W      = $clog2(SCLK_DIV);
   localparam int BIT_W      = $clog2(CNT_MAX + 1);
   localparam int IDX_W      = $clog2(BLOCK_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_LEN - 1);

   typedef enum logic [1:0] {IDLE, CONV, GAP} state_t;

   state_t                  state, state_nxt;
   logic [DIV_W-1:0]        div_cnt;
   logic                    half;
   logic [BIT_W-1:0]        bit_cnt;
   logic                    bit_end, shift_en, frame_done, enabled;
   logic                    single_mode, blk_fin;
   logic [IDX_W-1:0]        idx;
   logic [NUM_CH-1:0][15:0] lane_word;
   logic [NUM_CH-1:0][15:0] tdata_q;

   assign bit_end    = half && (div_cnt == DIV_W'(SCLK_DIV - 1));
   assign shift_en   = (state == CONV) && bit_end && (bit_cnt >= BIT_W'(LEAD_BITS));
   assign frame_done = (state == CONV) && bit_end && (bit_cnt == BIT_W'(FRAME_BITS - 1));
   // a single-mode block overrides run until its last sample has been taken
   assign enabled    = single_mode ? !blk_fin : run;

   assign cs1     = (state != CONV);
   assign busy    = (state != IDLE);
   assign m_tdata = tdata_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run || single) state_nxt = CONV;
         CONV:    if (frame_done) state_nxt = GAP;
         GAP:     if (bit_end && bit_cnt == BIT_W'(GAP_BITS - 1))
                     state_nxt = enabled ? CONV : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // bit-period timer: half=0 is the sclk-low half, half=1 the sclk-high half
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         half    <= 1'b0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
      end else if (state_nxt != state || state == IDLE) begin
         div_cnt <= '0;
         half    <= 1'b0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
      end else if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
         div_cnt <= '0;
         half    <= ~half;
         sclk    <= (state == CONV) && !half;
         if (half) bit_cnt <= bit_cnt + BIT_W'(1);
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      adc_capture_lane #(
         .DATA_BITS  (DATA_BITS),
         .SIGNED_OUT (SIGNED_OUT)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .shift_en (shift_en),
         .din      (adc_din[g]),
         .word     (lane_word[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_tvalid    <= 1'b0;
         m_tlast     <= 1'b0;
         tdata_q     <= '0;
         overrun_cnt <= '0;
         idx         <= '0;
         single_mode <= 1'b0;
         blk_fin     <= 1'b0;
         block_done  <= 1'b0;
      end else begin
         block_done <= 1'b0;
         if (state == IDLE && single) begin
            single_mode <= 1'b1;
            blk_fin     <= 1'b0;
            idx         <= '0;
         end
         if (frame_done) begin
            // a held sample is never overwritten; the new one is dropped and counted
            if (m_tvalid && !m_tready) begin
               if (overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
            end else begin
               m_tvalid <= 1'b1;
               tdata_q  <= lane_word;
               m_tlast  <= (idx == IDX_LAST);
               idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
               if (single_mode && idx == IDX_LAST) blk_fin <= 1'b1;
            end
         end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
         end
         if (state == GAP && state_nxt == IDLE && single_mode) begin
            block_done  <= 1'b1;
            single_mode <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_adc_capture_multi.sv
// Randomized bench for adc_capture_multi: serial ADC models feed a signed and an
// unsigned instance; a transaction-level model predicts the stream outputs.

module tb_adc_capture_multi;
   localparam int NCH = 2, DB = 10, LB = 5, SD = 7, GB = 2, BL = 4;
   localparam int FB = LB + DB;

   logic clk = 1'b0, reset = 1'b1, run = 1'b0, single = 1'b0, m_tready = 1'b0;
   logic [NCH-1:0] adc_din = '0;
   logic sclk, cs1, m_tvalid, m_tlast, busy, block_done;
   logic sclk_u, cs1_u, m_tvalid_u, m_tlast_u, busy_u, block_done_u;
   logic [16*NCH-1:0] m_tdata, m_tdata_u;
   logic [15:0] overrun_cnt, overrun_cnt_u;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   adc_capture_multi #(.NUM_CH(NCH), .DATA_BITS(DB), .LEAD_BITS(LB), .SCLK_DIV(SD),
      .GAP_BITS(GB), .BLOCK_LEN(BL), .SIGNED_OUT(1'b1)) u_dut (
      .clk(clk), .reset(reset), .run(run), .single(single), .adc_din(adc_din),
      .sclk(sclk), .cs1(cs1), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tdata(m_tdata), .busy(busy), .block_done(block_done),
      .overrun_cnt(overrun_cnt));

   adc_capture_multi #(.NUM_CH(NCH), .DATA_BITS(DB), .LEAD_BITS(LB), .SCLK_DIV(SD),
      .GAP_BITS(GB), .BLOCK_LEN(BL), .SIGNED_OUT(1'b0)) u_dut_u (
      .clk(clk), .reset(reset), .run(run), .single(single), .adc_din(adc_din),
      .sclk(sclk_u), .cs1(cs1_u), .m_tvalid(m_tvalid_u), .m_tready(m_tready),
      .m_tlast(m_tlast_u), .m_tdata(m_tdata_u), .busy(busy_u), .block_done(block_done_u),
      .overrun_cnt(overrun_cnt_u));

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // offset-binary code to signed value, expressed arithmetically
   function automatic logic [15:0] to_s(logic [DB-1:0] r);
      return 16'(int'(r) - (1 << (DB - 1)));
   endfunction

   // ADC models: new random (or forced) word each frame, random lead bits
   logic [DB-1:0] raw_cur [NCH];
   logic [FB-1:0] frame   [NCH];
   logic [DB-1:0] frc_val [NCH];
   bit frc_en = 1'b0;
   int rise_i = 0;

   always @(negedge cs1) begin
      for (int c = 0; c < NCH; c++) begin
         raw_cur[c] = frc_en ? frc_val[c] : DB'($urandom);
         frame[c]   = {LB'($urandom), raw_cur[c]};
      end
      rise_i = 0;
   end

   always @(posedge sclk) begin
      #1;
      if (rise_i < FB)
         for (int c = 0; c < NCH; c++) adc_din[c] = frame[c][FB-1-rise_i];
      rise_i++;
   end

   // reference model and timing monitor, evaluated between active edges
   bit mon_on = 1'b0, rst_p = 1'b1, rdy_p = 1'b0, cs1_p = 1'b1, sclk_p = 1'b0;
   bit sgl_acc = 1'b0, sgl_p = 1'b0;
   bit mv = 1'b0, mlast = 1'b0;
   logic [16*NCH-1:0] es_m = '0, eu_m = '0;
   int midx = 0, movr = 0;
   int comp_cnt = 0, xfer_cnt = 0, last_cnt = 0, bd_cnt = 0;
   int rises = 0, cs_len = 0, lo_len = 0, hi_len = 0;

   always @(negedge clk) begin
      bit comp;
      if (mon_on) begin
         comp = !cs1_p && cs1 && !rst_p;
         if (rst_p) begin
            mv = 1'b0; mlast = 1'b0; movr = 0; midx = 0; es_m = '0; eu_m = '0;
         end else begin
            if (sgl_p) midx = 0;
            if (comp) begin
               comp_cnt++;
               chk("cs1_low_len", cs_len, 2 * SD * FB);
               chk("sclk_rises", rises, FB);
               if (mv && !rdy_p) begin
                  if (movr < 65535) movr++;
               end else begin
                  mv = 1'b1;
                  for (int c = 0; c < NCH; c++) begin
                     es_m[16*c +: 16] = to_s(raw_cur[c]);
                     eu_m[16*c +: 16] = 16'(raw_cur[c]);
                  end
                  mlast = (midx == BL - 1);
                  midx  = (midx + 1) % BL;
               end
            end else if (mv && rdy_p) begin
               mv = 1'b0;
            end
         end

         if (!cs1 && cs1_p) begin
            cs_len = 0; rises = 0; lo_len = 0; hi_len = 0;
         end else if (!rst_p) begin
            if (sclk && !sclk_p) begin chk("sclk_low", lo_len, SD); lo_len = 0; rises++; end
            if (!sclk && sclk_p) begin chk("sclk_high", hi_len, SD); hi_len = 0; end
         end
         if (!cs1) cs_len++;
         if (!cs1 && !sclk) lo_len++;
         if (sclk) hi_len++;

         chk("stream", {m_tvalid, m_tlast, m_tvalid_u, m_tlast_u, m_tdata, m_tdata_u,
                        overrun_cnt, overrun_cnt_u},
                       {mv, mlast, mv, mlast, es_m, eu_m, 16'(movr), 16'(movr)});

         if (m_tvalid && m_tready) begin
            xfer_cnt++;
            if (m_tlast) last_cnt++;
         end
         if (block_done) bd_cnt++;
      end
      rst_p  = reset;
      rdy_p  = m_tready;
      cs1_p  = cs1;
      sclk_p = sclk;
      sgl_p  = sgl_acc;
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_comp(int n, int budget, string tag);
      int tgt = comp_cnt + n;
      int k = 0;
      while (comp_cnt < tgt && k < budget) begin cyc(1); k++; end
      chk(tag, comp_cnt >= tgt, 1);
   endtask

   task automatic wait_idle(int budget);
      int k = 0;
      while (busy && k < budget) begin cyc(1); k++; end
      chk("idle", busy, 0);
   endtask

   task automatic wait_bd(int budget);
      int tgt = bd_cnt + 1;
      int k = 0;
      while (bd_cnt < tgt && k < budget) begin cyc(1); k++; end
      chk("block_done_seen", bd_cnt >= tgt, 1);
   endtask

   initial begin
      int x0, l0, b0, k;
      for (int c = 0; c < NCH; c++) frc_val[c] = '0;
      reset = 1'b1;
      cyc(3);
      mon_on = 1'b1;
      @(negedge clk);
      chk("reset_state", {sclk, cs1, m_tvalid, m_tlast, busy, block_done, overrun_cnt, m_tdata},
                         {1'b0, 1'b1, 4'b0, 16'h0, 32'h0});
      cyc(1);
      reset = 1'b0;

      // full-scale and zero codes
      frc_en = 1'b1; frc_val[0] = 10'h3FF; frc_val[1] = 10'h000;
      m_tready = 1'b1; run = 1'b1;
      wait_comp(2, 1000, "wait_fullscale");
      chk("signed_lanes", m_tdata, 32'hFE00_01FF);
      chk("unsigned_lanes", m_tdata_u, 32'h0000_03FF);
      frc_val[0] = 10'h200; frc_val[1] = 10'h200;
      wait_comp(2, 1000, "wait_midscale");
      chk("unsigned_mid", m_tdata_u[15:0], 16'h0200);
      chk("signed_mid", m_tdata[15:0], 16'h0000);

      // random data with random back-pressure, including long stalls
      frc_en = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         m_tready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      for (int i = 0; i < 12; i++) begin
         m_tready = 1'($urandom_range(0, 1));
         cyc($urandom_range(20, 500));
      end
      m_tready = 1'b1; run = 1'b0;
      wait_idle(1000);

      // sustained stall: first sample held, later ones dropped
      reset = 1'b1; cyc(1); reset = 1'b0;
      m_tready = 1'b0; run = 1'b1;
      wait_comp(3, 2000, "wait_stall");
      chk("overrun_two", overrun_cnt, 2);
      chk("held_valid", {m_tvalid, m_tlast}, 2'b10);
      m_tready = 1'b1;
      wait_comp(4, 2000, "wait_after_stall");
      run = 1'b0;
      wait_idle(1000);

      // single block, with a second single pulse while busy
      x0 = xfer_cnt; l0 = last_cnt; b0 = bd_cnt;
      single = 1'b1; sgl_acc = 1'b1; cyc(1); single = 1'b0; sgl_acc = 1'b0;
      cyc(300);
      single = 1'b1; cyc(1); single = 1'b0;
      wait_bd(2000);
      cyc(5);
      chk("block_xfers", xfer_cnt - x0, BL);
      chk("block_tlast", last_cnt - l0, 1);
      chk("block_done_width", bd_cnt - b0, 1);
      chk("block_busy", busy, 0);

      // run and single together: block first, then continuous
      run = 1'b1; single = 1'b1; sgl_acc = 1'b1; cyc(1); single = 1'b0; sgl_acc = 1'b0;
      wait_bd(2000);
      cyc(2);
      chk("run_after_block", busy, 1);
      run = 1'b0;
      wait_idle(1000);

      // reset during bit 8 of a frame, then a fresh capture
      run = 1'b1;
      k = 0;
      while (!(!cs1 && rises == 9) && k < 1000) begin cyc(1); k++; end
      chk("reach_bit8", rises, 9);
      reset = 1'b1; cyc(1);
      chk("abort_state", {cs1, sclk, m_tvalid}, 3'b100);
      reset = 1'b0;
      wait_comp(2, 1000, "wait_after_abort");
      run = 1'b0;
      wait_idle(1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
